acq_scheduler: RTL and testbench

Measurement sequencer for the acoustic camera angle path. While enabled, it periodically starts the microphone subsystem, waits for its completion pulse, and triggers the angle calculation. It then averages 2^AVG_LOG2 angle results and hands each average to the UART transmitter with a ready/enable handshake. It sits between the pad-level run control, the mic subsystem, the angle calculator and the UART.

---
 rtl/acq_scheduler.sv | 148 ++++++++++++++
 tb/tb_acq_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_scheduler.sv
// Measurement sequencer for the acoustic camera angle path: periodic mic capture,
// angle calculation, 2^AVG_LOG2-sample averaging and UART hand-off.
module acq_scheduler #(
  parameter int unsigned PERIOD_CYC  = 6000000,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned DW          = 16
) (
  input  logic                 clk_60MHz,
  input  logic                 rst,
  input  logic                 run,
  output logic                 subsys_start,
  input  logic                 subsys_done,
  output logic                 calc_ena,
  input  logic                 calc_done,
  input  logic signed [DW-1:0] angel,
  input  logic                 uart_ready,
  output logic                 uart_ena,
  output logic signed [DW-1:0] uart_data,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int unsigned PW    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned AW    = DW + AVG_LOG2;
  localparam int unsigned CW    = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, START, WAIT_MIC, CALC, WAIT_CALC, SEND_WAIT, SEND
  } state_t;

  state_t               state;
  logic [PW-1:0]        per_cnt;
  logic [TW-1:0]        tmo;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;
  logic                 tick;
  logic                 tmo_hit;

  assign tick    = run && (per_cnt == PW'(PERIOD_CYC - 1));
  assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));
  assign cnt_inc = cnt + CW'(1);

  // Free-running measurement period; holds while run is low, restarts from IDLE.
  always_ff @(posedge clk_60MHz) begin
    if (rst || state == IDLE) begin
      per_cnt <= '0;
    end else if (run) begin
      per_cnt <= tick ? '0 : per_cnt + PW'(1);
    end
  end

  // Sequencer; pulses are set on the transition into the state that owns them.
  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      state        <= IDLE;
      tmo          <= '0;
      acc          <= '0;
      cnt          <= '0;
      subsys_start <= 1'b0;
      calc_ena     <= 1'b0;
      uart_ena     <= 1'b0;
      uart_data    <= '0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      subsys_start <= 1'b0;
      calc_ena     <= 1'b0;
      uart_ena     <= 1'b0;
      case (state)
        IDLE: begin
          acc  <= '0;
          cnt  <= '0;
          busy <= 1'b0;
          if (run) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!run) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (tick) begin
            state        <= START;
            subsys_start <= 1'b1;
            busy         <= 1'b1;
          end
        end
        START: begin
          state <= WAIT_MIC;
          tmo   <= '0;
        end
        WAIT_MIC: begin
          if (subsys_done) begin
            state    <= CALC;
            calc_ena <= 1'b1;
          end else if (tmo_hit) begin
            state       <= WAIT_TICK;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        CALC: begin
          state <= WAIT_CALC;
          tmo   <= '0;
        end
        WAIT_CALC: begin
          if (calc_done) begin
            acc <= acc + AW'(angel);
            cnt <= cnt_inc;
            if (cnt_inc == CW'(NSAMP)) begin
              state <= SEND_WAIT;
            end else begin
              state <= WAIT_TICK;
              busy  <= 1'b0;
            end
          end else if (tmo_hit) begin
            // Timed-out sample is dropped; earlier samples stay in the average.
            state       <= WAIT_TICK;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        SEND_WAIT: begin
          if (uart_ready) begin
            state     <= SEND;
            uart_ena  <= 1'b1;
            uart_data <= DW'(acc >>> AVG_LOG2);
          end
        end
        SEND: begin
          acc   <= '0;
          cnt   <= '0;
          busy  <= 1'b0;
          state <= run ? WAIT_TICK : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// Scoreboard bench for acq_scheduler with mic/calc stubs replying 3 cycles after each request.
module tb_acq_scheduler;

  logic        clk_60MHz = 1'b0;
  logic        rst;
  logic        run;
  logic        subsys_start;
  logic        subsys_done;
  logic        calc_ena;
  logic        calc_done;
  logic [15:0] angel;
  logic        uart_ready;
  logic        uart_ena;
  logic [15:0] uart_data;
  logic        timeout_err;
  logic        busy;

  acq_scheduler #(
    .PERIOD_CYC (20),
    .TIMEOUT_CYC(8),
    .AVG_LOG2   (2),
    .DW         (16)
  ) dut (
    .clk_60MHz   (clk_60MHz),
    .rst         (rst),
    .run         (run),
    .subsys_start(subsys_start),
    .subsys_done (subsys_done),
    .calc_ena    (calc_ena),
    .calc_done   (calc_done),
    .angel       (angel),
    .uart_ready  (uart_ready),
    .uart_ena    (uart_ena),
    .uart_data   (uart_data),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk_60MHz = ~clk_60MHz;

  int cyc = 0;
  always @(posedge clk_60MHz) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [15:0] ang_q[$];
  logic [15:0] exp_q[$];

  // Stub state shared with monitor and main sequence
  int mic_t = 0, calc_t = 0;
  int mic_idx = 0, withhold_idx = -1, withheld_cyc = 0;
  int last_mic_done = 0, last_calc_done = 0;

  initial begin
    subsys_done = 1'b0;
    calc_done   = 1'b0;
    angel       = '0;
    forever begin
      @(negedge clk_60MHz);
      subsys_done = 1'b0;
      calc_done   = 1'b0;
      if (mic_t > 0) begin
        mic_t--;
        if (mic_t == 0) begin
          subsys_done   = 1'b1;
          last_mic_done = cyc;
        end
      end
      if (calc_t > 0) begin
        calc_t--;
        if (calc_t == 0) begin
          calc_done      = 1'b1;
          last_calc_done = cyc;
          angel          = (ang_q.size() > 0) ? ang_q.pop_front() : 16'h0000;
        end
      end
      if (subsys_start) begin
        mic_idx++;
        if (mic_idx == withhold_idx) withheld_cyc = cyc;
        else mic_t = 3;
      end
      if (calc_ena) calc_t = 3;
    end
  end

  int n_start = 0, n_calc = 0, last_start = -1, ready_rise = 0;
  bit per_chk_en = 1'b1;
  bit lat_mode = 1'b0;
  logic [15:0] mon_exp;

  always @(negedge clk_60MHz) begin
    if (!rst) begin
      if (subsys_start) begin
        n_start++;
        if (per_chk_en && last_start >= 0) chk("start_period", cyc - last_start, 20);
        last_start = cyc;
      end
      if (calc_ena) begin
        n_calc++;
        chk("calc_lat", cyc - last_mic_done, 1);
      end
      if (uart_ena) begin
        if (exp_q.size() == 0) begin
          chk("uart_extra", 32'(uart_ena), 0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("uart_data", 32'(uart_data), 32'(mon_exp));
        end
        if (!lat_mode) chk("send_lat", cyc - last_calc_done, 2);
        else chk("ready_lat", cyc - ready_rise, 1);
      end
    end
  end

  task automatic wait_for(input string tag, input int which, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk_60MHz);
      case (which)
        0:       seen = subsys_start;
        1:       seen = calc_ena;
        2:       seen = uart_ena;
        default: seen = timeout_err;
      endcase
    end
    chk({"wait_", tag}, 32'(seen), 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_start"}, 32'(subsys_start), 0);
    chk({tag, "_calc"},  32'(calc_ena), 0);
    chk({tag, "_uena"},  32'(uart_ena), 0);
    chk({tag, "_udata"}, 32'(uart_data), 0);
    chk({tag, "_tmo"},   32'(timeout_err), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int run_cyc, start_base, calc_base, cnt_s, cnt_u;

  initial begin
    rst = 1'b1; run = 1'b0; uart_ready = 1'b1;
    repeat (3) @(negedge clk_60MHz);
    chk_outputs_zero("rst");
    rst = 1'b0;
    @(negedge clk_60MHz);

    // Plain averages, positive then negative with floor rounding
    foreach (ang_q[i]) ang_q.delete(i);
    ang_q.push_back(16'd10); ang_q.push_back(16'd20); ang_q.push_back(16'd30); ang_q.push_back(16'd41);
    exp_q.push_back(16'd25);
    ang_q.push_back(16'hFFFD); ang_q.push_back(16'hFFFC); ang_q.push_back(16'hFFFC); ang_q.push_back(16'hFFFC);
    exp_q.push_back(16'hFFFC);
    run = 1'b1;
    run_cyc = cyc;
    wait_for("first_start", 0, 40);
    chk("first_start_lat", cyc - run_cyc, 21);
    wait_for("uart1", 2, 200);
    wait_for("uart2", 2, 200);

    // Mic timeout on the 2nd sample of the next average
    chk("tmo_clear", 32'(timeout_err), 0);
    withhold_idx = mic_idx + 2;
    start_base = n_start;
    calc_base = n_calc;
    ang_q.push_back(16'd100); ang_q.push_back(16'd200); ang_q.push_back(16'd300); ang_q.push_back(16'd404);
    exp_q.push_back(16'd251);
    wait_for("tmo", 3, 100);
    chk("tmo_lat", cyc - withheld_cyc, 9);
    wait_for("uart3", 2, 250);
    chk("tmo_starts", n_start - start_base, 5);
    chk("tmo_calcs", n_calc - calc_base, 4);

    // UART back-pressure: ticks dropped while waiting to send
    uart_ready = 1'b0;
    per_chk_en = 1'b0;
    ang_q.push_back(16'd7); ang_q.push_back(16'd8); ang_q.push_back(16'd9); ang_q.push_back(16'd10);
    exp_q.push_back(16'd8);
    for (int k = 0; k < 4; k++) wait_for("bp_calc", 1, 100);
    repeat (6) @(negedge clk_60MHz);
    chk("sendwait_busy", 32'(busy), 1);
    cnt_s = 0; cnt_u = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_60MHz);
      if (subsys_start) cnt_s++;
      if (uart_ena) cnt_u++;
    end
    chk("bp_no_start", cnt_s, 0);
    chk("bp_no_send", cnt_u, 0);
    lat_mode = 1'b1;
    ready_rise = cyc;
    uart_ready = 1'b1;
    wait_for("uart4", 2, 10);
    @(negedge clk_60MHz);
    lat_mode = 1'b0;

    // Run dropped in WAIT_MIC: sequence completes, partial average discarded
    ang_q.push_back(16'd1000); ang_q.push_back(16'd2000);
    wait_for("s5_start_a", 0, 60);
    wait_for("s5_start_b", 0, 60);
    @(negedge clk_60MHz);
    run = 1'b0;
    wait_for("s5_calc", 1, 20);
    cnt_s = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_60MHz);
      if (subsys_start) cnt_s++;
    end
    chk("stop_no_start", cnt_s, 0);
    chk("stop_idle_busy", 32'(busy), 0);
    ang_q.push_back(16'd1); ang_q.push_back(16'd2); ang_q.push_back(16'd3); ang_q.push_back(16'd5);
    exp_q.push_back(16'd2);
    run = 1'b1;
    wait_for("uart5", 2, 250);

    // Reset pulsed in WAIT_CALC; the late calc_done must not count
    chk("tmo_sticky", 32'(timeout_err), 1);
    ang_q.push_back(16'd5000);
    wait_for("s6_calc", 1, 100);
    @(negedge clk_60MHz);
    rst = 1'b1;
    @(negedge clk_60MHz);
    chk_outputs_zero("midrst");
    rst = 1'b0;
    ang_q.push_back(16'd40); ang_q.push_back(16'd40); ang_q.push_back(16'd40); ang_q.push_back(16'd44);
    exp_q.push_back(16'd41);
    wait_for("uart6", 2, 300);

    repeat (5) @(negedge clk_60MHz);
    chk("sb_drain", exp_q.size(), 0);
    chk("ang_drain", ang_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
